instr_encoder_loader: RTL and testbench

//  Encodes assembler-level instruction records (class, cond, registers, immediate) into 32-bit words
//  in the exact format the CPU control decoder consumes, and writes them sequentially into instruction memory.

---
 rtl/instr_encoder_loader.sv | 176 +++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Encodes assembler instruction records into 32-bit control-decoder words and writes them
// sequentially into instruction RAM, with legality/range checks and full detection.
module instr_encoder_loader #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_cls,
    input  logic [3:0]    in_cond,
    input  logic [3:0]    in_rd,
    input  logic [3:0]    in_rn,
    input  logic [3:0]    in_rm,
    input  logic [23:0]   in_imm,
    input  logic          in_immsel,
    input  logic          in_setf,
    input  logic          in_last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          done,
    output logic          busy,
    output logic          err_illegal,
    output logic          err_range,
    output logic          err_full
);

    typedef enum logic [2:0] {StIdle, StAccept, StEnc, StWr, StDone, StFull} state_e;

    typedef struct packed {
        logic [3:0]  cls;
        logic [3:0]  cond;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [23:0] imm;
        logic        immsel;
        logic        setf;
        logic        last;
    } rec_t;

    state_e          state_q, state_d;
    rec_t            rec_q, rec_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [31:0]     word_q, word_d;
    logic            err_ill_q, err_ill_d;
    logic            err_rng_q, err_rng_d;
    logic            err_full_q, err_full_d;

    logic [31:0]     enc;
    logic            illegal;
    logic            range_bad;

    // Combinational encoder over the captured record; consumed only in StEnc.
    always_comb begin
        enc       = '0;
        illegal   = 1'b0;
        range_bad = 1'b0;
        enc[31:28] = rec_q.cond;
        if (rec_q.cls <= 4'd5) begin
            enc[27:26] = 2'b00;
            enc[24]    = rec_q.immsel;
            enc[23:21] = rec_q.cls[2:0];
            enc[20]    = (rec_q.cls == 4'd5) ? 1'b1 : rec_q.setf;
            enc[19:16] = rec_q.rn;
            enc[15:12] = (rec_q.cls == 4'd5) ? 4'd0 : rec_q.rd;
            if (rec_q.immsel) begin
                enc[7:0]  = rec_q.imm[7:0];
                range_bad = |rec_q.imm[23:8];
            end else begin
                enc[3:0] = rec_q.rm;
            end
        end else if (rec_q.cls == 4'd6) begin
            enc[27:26] = 2'b01;
            enc[25:24] = 2'b10;
            enc[23:0]  = rec_q.imm;
        end else if (rec_q.cls <= 4'd8) begin
            enc[27:26] = 2'b10;
            enc[24:21] = 4'b1100;
            enc[20]    = (rec_q.cls == 4'd7);
            enc[19:16] = rec_q.rn;
            enc[15:12] = rec_q.rd;
            enc[11:0]  = rec_q.imm[11:0];
            range_bad  = |rec_q.imm[23:12];
        end else begin
            illegal = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rec_d      = rec_q;
        addr_d     = addr_q;
        word_d     = word_q;
        err_ill_d  = err_ill_q;
        err_rng_d  = err_rng_q;
        err_full_d = err_full_q;
        unique case (state_q)
            StIdle: ;
            StAccept: begin
                if (in_valid) begin
                    rec_d   = '{cls: in_cls, cond: in_cond, rd: in_rd, rn: in_rn, rm: in_rm,
                                imm: in_imm, immsel: in_immsel, setf: in_setf, last: in_last};
                    state_d = StEnc;
                end
            end
            StEnc: begin
                if (illegal) begin
                    err_ill_d = 1'b1;
                    state_d   = StAccept;
                end else if (range_bad) begin
                    err_rng_d = 1'b1;
                    state_d   = StAccept;
                end else begin
                    word_d  = enc;
                    state_d = StWr;
                end
            end
            StWr: begin
                // Address saturates at the top word; FULL unless this was the program's last.
                if (addr_q == AW'(DEPTH - 1)) begin
                    state_d = rec_q.last ? StDone : StFull;
                end else begin
                    addr_d  = addr_q + AW'(1);
                    state_d = rec_q.last ? StDone : StAccept;
                end
            end
            StDone: state_d = StIdle;
            StFull: begin
                if (in_valid) err_full_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
        if (start) begin
            state_d    = StAccept;
            addr_d     = '0;
            err_ill_d  = 1'b0;
            err_rng_d  = 1'b0;
            err_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            rec_q      <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            err_ill_q  <= 1'b0;
            err_rng_q  <= 1'b0;
            err_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rec_q      <= rec_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            err_ill_q  <= err_ill_d;
            err_rng_q  <= err_rng_d;
            err_full_q <= err_full_d;
        end
    end

    assign in_ready    = (state_q == StAccept);
    assign mem_we      = (state_q == StWr);
    assign done        = (state_q == StDone);
    assign busy        = (state_q != StIdle);
    assign mem_addr    = addr_q;
    assign mem_wdata   = word_q;
    assign err_illegal = err_ill_q;
    assign err_range   = err_rng_q;
    assign err_full    = err_full_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: a 256-deep instance for encoding/error/done tests
// and a 4-deep instance for full-memory behaviour.
module tb_instr_encoder_loader;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  cls, cond, rd, rn, rm;
    logic [23:0] imm;
    logic        immsel, setf, last;

    logic        start_a = 1'b0, valid_a = 1'b0;
    logic        ready_a, we_a, done_a, busy_a, eill_a, erng_a, efull_a;
    logic [7:0]  addr_a;
    logic [31:0] wdata_a;

    logic        start_b = 1'b0, valid_b = 1'b0;
    logic        ready_b, we_b, done_b, busy_b, eill_b, erng_b, efull_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;

    instr_encoder_loader #(.DEPTH(256), .AW(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .in_valid(valid_a), .in_ready(ready_a),
        .in_cls(cls), .in_cond(cond), .in_rd(rd), .in_rn(rn), .in_rm(rm), .in_imm(imm),
        .in_immsel(immsel), .in_setf(setf), .in_last(last), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wdata_a), .done(done_a), .busy(busy_a), .err_illegal(eill_a),
        .err_range(erng_a), .err_full(efull_a)
    );

    instr_encoder_loader #(.DEPTH(4), .AW(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .in_valid(valid_b), .in_ready(ready_b),
        .in_cls(cls), .in_cond(cond), .in_rd(rd), .in_rn(rn), .in_rm(rm), .in_imm(imm),
        .in_immsel(immsel), .in_setf(setf), .in_last(last), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wdata_b), .done(done_b), .busy(busy_b), .err_illegal(eill_b),
        .err_range(erng_b), .err_full(efull_b)
    );

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitors: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (we_a === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_write_addr", {24'd0, addr_a}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_addr", {24'd0, addr_a}, {24'd0, e.addr});
                chk("a_wdata", wdata_a, e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (we_b === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_write_addr", {30'd0, addr_b}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_addr", {30'd0, addr_b}, {24'd0, e.addr});
                chk("b_wdata", wdata_b, e.data);
            end
        end
    end

    task automatic set_rec(input logic [3:0] c, input logic [3:0] cd, input logic [3:0] d,
                           input logic [3:0] n, input logic [3:0] m, input logic [23:0] im,
                           input logic is, input logic s, input logic l);
        cls = c; cond = cd; rd = d; rn = n; rm = m; imm = im; immsel = is; setf = s; last = l;
    endtask

    // Returns at the negedge just after the handshake edge (DUT in ENC).
    task automatic send(input bit sel_b, input logic [3:0] c, input logic [3:0] cd,
                        input logic [3:0] d, input logic [3:0] n, input logic [3:0] m,
                        input logic [23:0] im, input logic is, input logic s, input logic l);
        int n_wait;
        @(negedge clk);
        set_rec(c, cd, d, n, m, im, is, s, l);
        if (sel_b) valid_b = 1'b1; else valid_a = 1'b1;
        n_wait = 0;
        while (((sel_b ? ready_b : ready_a) !== 1'b1) && n_wait < 50) begin
            @(negedge clk);
            n_wait++;
        end
        if (n_wait >= 50) begin
            chk("handshake_timeout", 32'd0, 32'd1);
            valid_a = 1'b0;
            valid_b = 1'b0;
        end else begin
            @(negedge clk);
            valid_a = 1'b0;
            valid_b = 1'b0;
        end
    endtask

    task automatic pulse_start(input bit sel_b);
        @(negedge clk);
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        set_rec(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 24'd0, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("rst_ready", {31'd0, ready_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_we", {31'd0, we_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_errs", {29'd0, eill_a, erng_a, efull_a}, 32'd0);
        chk("rst_addr", {24'd0, addr_a}, 32'd0);
        chk("rst_wdata", wdata_a, 32'd0);
        reset_n = 1'b1;
        idle(1);

        // Encoding and latency
        pulse_start(1'b0);
        chk("start_busy", {31'd0, busy_a}, 32'd1);
        chk("start_ready", {31'd0, ready_a}, 32'd1);
        qa.push_back('{8'd0, 32'hE102_1005});
        send(1'b0, 4'd0, 4'hE, 4'd1, 4'd2, 4'd0, 24'd5, 1'b1, 1'b0, 1'b0);
        chk("lat_n1_we", {31'd0, we_a}, 32'd0);
        idle(1);
        chk("lat_n2_we", {31'd0, we_a}, 32'd1);
        chk("lat_n2_ready", {31'd0, ready_a}, 32'd0);
        idle(1);
        chk("lat_n3_ready", {31'd0, ready_a}, 32'd1);

        qa.push_back('{8'd1, 32'hE0B3_0004});
        send(1'b0, 4'd5, 4'hE, 4'd7, 4'd3, 4'd4, 24'd0, 1'b0, 1'b0, 1'b0);
        qa.push_back('{8'd2, 32'h06FF_FFFE});
        send(1'b0, 4'd6, 4'h0, 4'd0, 4'd0, 4'd0, 24'hFF_FFFE, 1'b0, 1'b0, 1'b0);
        qa.push_back('{8'd3, 32'hE996_5010});
        send(1'b0, 4'd7, 4'hE, 4'd5, 4'd6, 4'd0, 24'h10, 1'b0, 1'b0, 1'b0);
        qa.push_back('{8'd4, 32'hE986_5010});
        send(1'b0, 4'd8, 4'hE, 4'd5, 4'd6, 4'd0, 24'h10, 1'b0, 1'b0, 1'b0);
        qa.push_back('{8'd5, 32'hE100_00FF});
        send(1'b0, 4'd0, 4'hE, 4'd0, 4'd0, 4'd0, 24'd255, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Range and illegal-class errors
        send(1'b0, 4'd0, 4'hE, 4'd1, 4'd2, 4'd0, 24'd300, 1'b1, 1'b0, 1'b0);
        idle(1);
        chk("range_flag", {31'd0, erng_a}, 32'd1);
        chk("range_no_illegal", {31'd0, eill_a}, 32'd0);
        chk("range_addr", {24'd0, addr_a}, 32'd6);
        chk("range_ready", {31'd0, ready_a}, 32'd1);
        send(1'b0, 4'd12, 4'hE, 4'd1, 4'd2, 4'd0, 24'd1, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("illegal_flag", {31'd0, eill_a}, 32'd1);
        chk("illegal_addr", {24'd0, addr_a}, 32'd6);
        send(1'b0, 4'd7, 4'hE, 4'd1, 4'd2, 4'd0, 24'd4096, 1'b0, 1'b0, 1'b0);
        idle(1);
        chk("getstr_range_addr", {24'd0, addr_a}, 32'd6);

        // Last record and done pulse
        pulse_start(1'b0);
        chk("restart_errs", {29'd0, eill_a, erng_a, efull_a}, 32'd0);
        chk("restart_addr", {24'd0, addr_a}, 32'd0);
        qa.push_back('{8'd0, 32'h1134_2080});
        send(1'b0, 4'd1, 4'h1, 4'd2, 4'd4, 4'd0, 24'h80, 1'b1, 1'b1, 1'b0);
        qa.push_back('{8'd1, 32'hE090_3002});
        send(1'b0, 4'd4, 4'hE, 4'd3, 4'd0, 4'd2, 24'd0, 1'b0, 1'b1, 1'b1);
        chk("last_enc_done", {31'd0, done_a}, 32'd0);
        idle(1);
        chk("last_wr_done", {31'd0, done_a}, 32'd0);
        idle(1);
        chk("done_pulse", {31'd0, done_a}, 32'd1);
        chk("done_busy", {31'd0, busy_a}, 32'd1);
        idle(1);
        chk("done_clear", {31'd0, done_a}, 32'd0);
        chk("idle_busy", {31'd0, busy_a}, 32'd0);
        chk("idle_addr", {24'd0, addr_a}, 32'd2);

        // Reset asserted while a record is in ENC
        pulse_start(1'b0);
        send(1'b0, 4'd0, 4'hE, 4'd1, 4'd2, 4'd0, 24'd9, 1'b1, 1'b0, 1'b0);
        reset_n = 1'b0;
        idle(1);
        chk("midrst_busy", {31'd0, busy_a}, 32'd0);
        chk("midrst_we", {31'd0, we_a}, 32'd0);
        chk("midrst_wdata", wdata_a, 32'd0);
        reset_n = 1'b1;
        idle(4);
        chk("midrst_idle", {31'd0, busy_a}, 32'd0);

        // Full detection on the 4-deep instance
        pulse_start(1'b1);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] w;
            w = 32'hE102_1000 | k;
            qb.push_back('{k[7:0], w});
            send(1'b1, 4'd0, 4'hE, 4'd1, 4'd2, 4'd0, k[23:0], 1'b1, 1'b0, 1'b0);
        end
        idle(2);
        chk("full_ready", {31'd0, ready_b}, 32'd0);
        chk("full_busy", {31'd0, busy_b}, 32'd1);
        chk("full_addr", {30'd0, addr_b}, 32'd3);
        chk("full_err_before", {31'd0, efull_b}, 32'd0);
        @(negedge clk);
        set_rec(4'd0, 4'hE, 4'd1, 4'd2, 4'd0, 24'd7, 1'b1, 1'b0, 1'b0);
        valid_b = 1'b1;
        idle(3);
        chk("full_err", {31'd0, efull_b}, 32'd1);
        chk("full_still_blocked", {31'd0, ready_b}, 32'd0);
        valid_b = 1'b0;
        pulse_start(1'b1);
        chk("full_restart_addr", {30'd0, addr_b}, 32'd0);
        chk("full_restart_err", {31'd0, efull_b}, 32'd0);
        chk("full_restart_ready", {31'd0, ready_b}, 32'd1);
        idle(3);

        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
